// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and constants for the OAM DMA arbiter slice.
package oam_dma_arbiter_pkg;

    typedef enum logic [1:0] {T1, T2, T3, T4} t_phase_t;

    typedef logic [1:0] dma_state_t;
    localparam dma_state_t IDLE  = 2'd0;
    localparam dma_state_t DELAY = 2'd1;
    localparam dma_state_t XFER  = 2'd2;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int unsigned OAM_LEN      = 160;
    localparam logic [15:0] HRAM_BASE    = 16'hFF80;

    // Sources at 0xE0 and above mirror work RAM 0x20 pages lower.
    function automatic logic [7:0] eff_src_hi(input logic [7:0] hi);
        return (hi < 8'hE0) ? hi : hi - 8'h20;
    endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and MMU-side bus signals seen by the OAM DMA arbiter.
interface oam_dma_arbiter_if;

    logic [15:0] cpu_addr;
    logic        cpu_req_read;
    logic        cpu_req_write;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [15:0] mmu_addr;
    logic        mmu_req_read;
    logic        mmu_req_write;
    logic [7:0]  mmu_wdata;
    logic [7:0]  mmu_rdata;
    logic        dma_active;

    modport master (
        output cpu_addr, cpu_req_read, cpu_req_write, cpu_wdata, mmu_rdata,
        input  cpu_rdata, mmu_addr, mmu_req_read, mmu_req_write, mmu_wdata, dma_active
    );

    modport slave (
        input  cpu_addr, cpu_req_read, cpu_req_write, cpu_wdata, mmu_rdata,
        output cpu_rdata, mmu_addr, mmu_req_read, mmu_req_write, mmu_wdata, dma_active
    );

endinterface

// File: rtl/oam_dma_arbiter_engine.sv
// Transfer FSM: source register, byte index, one-byte buffer and the state machine.
module oam_dma_engine
    import oam_dma_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  t_phase_t   i_phase,
    input  logic       i_reg_wr,
    input  logic [7:0] i_reg_wdata,
    input  logic [7:0] i_mmu_rdata,
    output dma_state_t o_state,
    output logic [7:0] o_idx,
    output logic [7:0] o_src_hi,
    output logic [7:0] o_buf
);

    localparam logic [7:0] IDX_LAST = 8'(OAM_LEN - 1);

    dma_state_t r_state;
    logic [7:0] r_idx;
    logic [7:0] r_src_hi;
    logic [7:0] r_buf;
    logic       r_armed;

    // r_armed marks that DELAY has seen its T1, so the exit at T4 covers a whole M-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_src_hi <= 8'hFF;
            r_buf    <= '0;
            r_armed  <= 1'b0;
        end else if (i_reg_wr) begin
            r_state  <= DELAY;
            r_idx    <= '0;
            r_src_hi <= i_reg_wdata;
            r_armed  <= 1'b0;
        end else begin
            case (r_state)
                DELAY: begin
                    if (i_phase == T4 && r_armed) begin
                        r_state <= XFER;
                        r_armed <= 1'b0;
                    end else if (i_phase == T1) begin
                        r_armed <= 1'b1;
                    end
                end
                XFER: begin
                    if (i_phase == T1)
                        r_buf <= i_mmu_rdata;
                    if (i_phase == T4) begin
                        if (r_idx == IDX_LAST) begin
                            r_state <= IDLE;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_state  = r_state;
    assign o_idx    = r_idx;
    assign o_src_hi = r_src_hi;
    assign o_buf    = r_buf;

endmodule

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter top: T-phase counter plus the CPU/DMA address mux onto the MMU bus.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    oam_dma_arbiter_if.slave bus
);

    t_phase_t   r_phase;
    dma_state_t w_state;
    logic [7:0] w_idx;
    logic [7:0] w_src_hi;
    logic [7:0] w_buf;
    logic       w_reg_hit;
    logic       w_reg_wr;
    logic       w_hram;
    logic       w_cpu_slot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_phase <= T1;
        else
            r_phase <= t_phase_t'(2'(r_phase) + 2'd1);
    end

    assign w_reg_hit  = (bus.cpu_addr == DMA_REG_ADDR);
    assign w_reg_wr   = w_reg_hit && bus.cpu_req_write;
    assign w_hram     = (bus.cpu_addr >= HRAM_BASE);
    assign w_cpu_slot = (r_phase == T2) || (r_phase == T3);

    oam_dma_engine u_engine (
        .clk         (clk),
        .rst_n       (reset),
        .i_phase     (r_phase),
        .i_reg_wr    (w_reg_wr),
        .i_reg_wdata (bus.cpu_wdata),
        .i_mmu_rdata (bus.mmu_rdata),
        .o_state     (w_state),
        .o_idx       (w_idx),
        .o_src_hi    (w_src_hi),
        .o_buf       (w_buf)
    );

    assign bus.dma_active = (w_state != IDLE);

    // CPU owns the bus in IDLE, or in T2/T3 for HRAM; DMA owns T1 (read) and T4 (write).
    always_comb begin
        bus.mmu_addr      = '0;
        bus.mmu_req_read  = 1'b0;
        bus.mmu_req_write = 1'b0;
        bus.mmu_wdata     = '0;
        bus.cpu_rdata     = 8'hFF;
        if (reset) begin
            if (w_reg_hit) begin
                if (bus.cpu_req_read)
                    bus.cpu_rdata = w_src_hi;
            end else if (w_state == IDLE || (w_cpu_slot && w_hram)) begin
                bus.mmu_addr      = bus.cpu_addr;
                bus.mmu_req_read  = bus.cpu_req_read;
                bus.mmu_req_write = bus.cpu_req_write;
                bus.mmu_wdata     = bus.cpu_wdata;
                bus.cpu_rdata     = bus.mmu_rdata;
            end
            if (w_state == XFER && r_phase == T1) begin
                bus.mmu_addr     = {eff_src_hi(w_src_hi), w_idx};
                bus.mmu_req_read = 1'b1;
            end else if (w_state == XFER && r_phase == T4 && !w_reg_wr) begin
                bus.mmu_addr      = OAM_BASE + {8'h00, w_idx};
                bus.mmu_req_write = 1'b1;
                bus.mmu_wdata     = w_buf;
            end
        end
    end

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 cpu_addr  input  16  CPU address for the current access.
REQ-004 cpu_req_read / cpu_req_write  input  1 each  CPU read/write request; never both high.
REQ-005 cpu_wdata  input  8  CPU write data.
REQ-006 cpu_rdata  output  8  read data returned to the CPU.
REQ-007 mmu_addr  output  16  address to the MMU; mmu_req_read / mmu_req_write  output  1 each.
REQ-008 mmu_wdata  output  8  write data to the MMU; mmu_rdata  input  8  MMU read data, combinationally valid while mmu_req_read is high.
REQ-009 dma_active  output  1  high in DELAY and XFER states.

Function
REQ-010 Internal 2-bit phase counter T1..T4 shall reset to T1 and advance every clk, so it stays aligned with the CPU T-phase.
REQ-011 A CPU write to 0xFF46 shall be absorbed by the arbiter, not forwarded to the MMU: src_hi <= cpu_wdata, state <= DELAY, idx <= 0.
REQ-012 A CPU read of 0xFF46 shall return src_hi and shall not be forwarded.
REQ-013 FSM states: IDLE, DELAY, XFER; IDLE->DELAY on an FF46 write; DELAY lasts exactly one full M-cycle (T1..T4) and then goes to XFER; XFER->IDLE after the idx=159 write.
REQ-014 Effective source high byte: src_hi if src_hi < 0xE0, else src_hi - 0x20.
REQ-015 Each XFER M-cycle, T1: mmu_addr = {eff_hi, idx}, mmu_req_read = 1; data latched into a byte buffer at the edge ending T1.
REQ-016 Each XFER M-cycle, T4: mmu_addr = 0xFE00 + idx, mmu_req_write = 1, mmu_wdata = buffer; idx increments at the edge ending T4.
REQ-017 Total transfer: 160 bytes in 160 M-cycles (640 clk) after DELAY; idx is 8-bit and never exceeds 159.
REQ-018 IDLE: CPU signals pass straight to the MMU on all phases; cpu_rdata = mmu_rdata.
REQ-019 DMA active, phases T2/T3: CPU access to 0xFF80–0xFFFF shall be forwarded; any other CPU read shall return 0xFF and any other CPU write shall be dropped (MMU requests low).
REQ-020 DMA active, phases T1/T4: the CPU has no MMU access; cpu_rdata = 0xFF.
REQ-021 DELAY, phases T1/T4: the MMU is idle (no requests).
REQ-022 An FF46 write while in DELAY or XFER shall restart the transfer: new src_hi, idx = 0, state = DELAY; the byte in flight shall not be written.
REQ-023 mmu_req_read and mmu_req_write shall never both be high.

Reset
REQ-024 On reset assertion, immediately: state = IDLE, phase = T1, idx = 0, src_hi = 0xFF, buffer = 0.
REQ-025 While in reset, outputs shall be: dma_active = 0, mmu_req_read = 0, mmu_req_write = 0, mmu_addr = 0, mmu_wdata = 0, cpu_rdata = 0xFF.
REQ-026 Reset during XFER shall abort the transfer with no further MMU writes; OAM contents already written shall be left as they are.

Structure
REQ-027 dma_state_t (IDLE/DELAY/XFER), DMA_REG_ADDR = 16'hFF46, OAM_BASE = 16'hFE00, OAM_LEN = 160 and HRAM_BASE = 16'hFF80 shall live in the shared types package.
REQ-028 The phase type shall reuse the package t_phase_t.
REQ-029 The transfer FSM shall be one sub-module, oam_dma_engine (state, idx, src_hi, buffer); the top level shall hold the phase counter and the address-based mux.

Verification
REQ-030 CPU writes 0x12 to 0xFF46 in IDLE -> dma_active rises at the next edge; first MMU read at 0x1200 in T1 after one M-cycle; first write at 0xFE00 in that cycle's T4.
REQ-031 Full transfer from 0xC0 -> 160 read/write pairs, 0xC000–0xC09F to 0xFE00–0xFE9F with matching data; dma_active falls after the idx=159 T4 write (644 clk after the FF46 write).
REQ-032 During XFER, CPU reads 0xC000 in T2 -> cpu_rdata = 0xFF with no MMU request; CPU reads 0xFF90 -> forwarded, cpu_rdata = mmu_rdata.
REQ-033 FF46 = 0xE5 -> source addresses 0xC500–0xC59F; CPU read of 0xFF46 returns 0xE5.
REQ-034 FF46 = 0x80 rewritten at idx = 50 with 0x90 -> no write for the in-flight byte, restart at 0x9000 -> 0xFE00 after DELAY.
REQ-035 reset asserted at idx = 80 -> all outputs at reset values asynchronously; no MMU write after deassertion; CPU pass-through restored.
